// File: rtl/host_seq_pkg.sv
// Shared types and widths for the host_seq program-load / run / result-drain sequencer.
package host_seq_pkg;

    localparam int IADDR_W = 8;
    localparam int INSTR_W = 9;
    localparam int DATA_W  = 8;
    localparam int CNT_W   = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_RUN   = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

endpackage

// File: rtl/host_seq.sv
// Host-side sequencer: streams a program into instruction memory, kicks the core, times the run,
// then streams RES_LEN result bytes back. Optional run watchdog under HOST_SEQ_TIMEOUT_EN.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | accepting instruction words into imem, wr_ptr advancing
// ST_START | one-cycle start pulse to the core, run counters cleared
// ST_RUN   | core executing; cycle_count runs until done (or watchdog)
// ST_DRAIN | results at RES_BASE+rd_idx offered to the host
module host_seq
    import host_seq_pkg::*;
#(
    parameter logic [IADDR_W-1:0] RES_BASE = 8'd64,
    parameter logic [IADDR_W-1:0] RES_LEN  = 8'd8,
    parameter logic [CNT_W-1:0]   TIMEOUT  = 16'd4096
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load_valid,
    input  logic [INSTR_W-1:0] load_data,
    input  logic               load_last,
    output logic               load_ready,
    output logic               imem_we,
    output logic [IADDR_W-1:0] imem_addr,
    output logic [INSTR_W-1:0] imem_wdata,
    output logic               start,
    input  logic               done,
    output logic [IADDR_W-1:0] dmem_raddr,
    input  logic [DATA_W-1:0]  dmem_rdata,
    output logic               res_valid,
    output logic [DATA_W-1:0]  res_data,
    input  logic               res_ready,
    output logic               busy,
    output logic [CNT_W-1:0]   cycle_count,
    output logic               timeout
);

    state_t             state;
    logic [IADDR_W-1:0] wr_ptr;
    logic [IADDR_W-1:0] rd_idx;
    logic               timeout_r;
    logic               beat;
    logic               last_result;

    // Write port is a pure pass-through of the accepted beat; reset gates it so a
    // word offered during reset never lands in memory.
    assign beat        = load_valid && load_ready && !reset;
    assign imem_we     = beat;
    assign imem_addr   = wr_ptr;
    assign imem_wdata  = load_data;

    assign dmem_raddr  = RES_BASE + rd_idx;
    assign res_data    = dmem_rdata;
    assign last_result = (rd_idx == RES_LEN - 8'd1);

`ifdef HOST_SEQ_TIMEOUT_EN
    logic run_expired;
    assign run_expired = (cycle_count == TIMEOUT - 16'd1);
    assign timeout     = timeout_r;
`else
    logic unused_timeout;
    assign unused_timeout = ^{TIMEOUT, timeout_r};
    assign timeout        = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            wr_ptr      <= '0;
            rd_idx      <= '0;
            cycle_count <= '0;
            timeout_r   <= 1'b0;
            start       <= 1'b0;
            res_valid   <= 1'b0;
            load_ready  <= 1'b1;
            busy        <= 1'b0;
        end else begin
            start <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (load_valid) begin
                        wr_ptr <= wr_ptr + 8'd1;
                        if (load_last) begin
                            state      <= ST_START;
                            start      <= 1'b1;
                            load_ready <= 1'b0;
                            busy       <= 1'b1;
                        end
                    end
                end

                ST_START: begin
                    cycle_count <= '0;
                    timeout_r   <= 1'b0;
                    state       <= ST_RUN;
                end

                ST_RUN: begin
                    if (cycle_count != CNT_MAX) begin
                        cycle_count <= cycle_count + 16'd1;
                    end
                    if (done) begin
                        if (RES_LEN == 8'd0) begin
                            state      <= ST_IDLE;
                            wr_ptr     <= '0;
                            load_ready <= 1'b1;
                            busy       <= 1'b0;
                        end else begin
                            state     <= ST_DRAIN;
                            rd_idx    <= '0;
                            res_valid <= 1'b1;
                        end
                    end
`ifdef HOST_SEQ_TIMEOUT_EN
                    else if (run_expired) begin
                        // Watchdog abandons the program; results are not trusted so DRAIN is skipped.
                        state      <= ST_IDLE;
                        timeout_r  <= 1'b1;
                        wr_ptr     <= '0;
                        load_ready <= 1'b1;
                        busy       <= 1'b0;
                    end
`endif
                end

                ST_DRAIN: begin
                    if (res_ready) begin
                        rd_idx <= rd_idx + 8'd1;
                        if (last_result) begin
                            state      <= ST_IDLE;
                            wr_ptr     <= '0;
                            res_valid  <= 1'b0;
                            load_ready <= 1'b1;
                            busy       <= 1'b0;
                        end
                    end
                end

                default: begin
                    state      <= ST_IDLE;
                    res_valid  <= 1'b0;
                    load_ready <= 1'b1;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_host_seq.sv
// Directed bench for host_seq: two instances (result base 64 and 252) share stimulus.
// Watchdog checks follow HOST_SEQ_TIMEOUT_EN.
module tb_host_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        load_valid;
    logic [8:0]  load_data;
    logic        load_last;
    logic        done;
    logic        res_ready;

    logic        load_ready_a, imem_we_a, start_a, res_valid_a, busy_a, timeout_a;
    logic [7:0]  imem_addr_a, dmem_raddr_a, dmem_rdata_a, res_data_a;
    logic [8:0]  imem_wdata_a;
    logic [15:0] cycle_count_a;

    logic        load_ready_b, imem_we_b, start_b, res_valid_b, busy_b, timeout_b;
    logic [7:0]  imem_addr_b, dmem_raddr_b, dmem_rdata_b, res_data_b;
    logic [8:0]  imem_wdata_b;
    logic [15:0] cycle_count_b;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    function automatic logic [7:0] mem_f(input logic [7:0] a);
        return {a[3:0], a[7:4]} ^ 8'hA5;
    endfunction

    assign dmem_rdata_a = mem_f(dmem_raddr_a);
    assign dmem_rdata_b = mem_f(dmem_raddr_b);

    host_seq #(.RES_BASE(8'd64), .RES_LEN(8'd8), .TIMEOUT(16'd16)) dut_a (
        .clk(clk), .reset(reset),
        .load_valid(load_valid), .load_data(load_data), .load_last(load_last),
        .load_ready(load_ready_a),
        .imem_we(imem_we_a), .imem_addr(imem_addr_a), .imem_wdata(imem_wdata_a),
        .start(start_a), .done(done),
        .dmem_raddr(dmem_raddr_a), .dmem_rdata(dmem_rdata_a),
        .res_valid(res_valid_a), .res_data(res_data_a), .res_ready(res_ready),
        .busy(busy_a), .cycle_count(cycle_count_a), .timeout(timeout_a)
    );

    host_seq #(.RES_BASE(8'd252), .RES_LEN(8'd8), .TIMEOUT(16'd16)) dut_b (
        .clk(clk), .reset(reset),
        .load_valid(load_valid), .load_data(load_data), .load_last(load_last),
        .load_ready(load_ready_b),
        .imem_we(imem_we_b), .imem_addr(imem_addr_b), .imem_wdata(imem_wdata_b),
        .start(start_b), .done(done),
        .dmem_raddr(dmem_raddr_b), .dmem_rdata(dmem_rdata_b),
        .res_valid(res_valid_b), .res_data(res_data_b), .res_ready(res_ready),
        .busy(busy_b), .cycle_count(cycle_count_b), .timeout(timeout_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_word(input logic [8:0] w, input logic last, input logic [7:0] exp_addr);
        load_valid = 1'b1;
        load_data  = w;
        load_last  = last;
        #1;
        chk("imem_we", {31'd0, imem_we_a}, 32'd1);
        chk("imem_addr_a", {24'd0, imem_addr_a}, {24'd0, exp_addr});
        chk("imem_addr_b", {24'd0, imem_addr_b}, {24'd0, exp_addr});
        chk("imem_wdata", {23'd0, imem_wdata_a}, {23'd0, w});
        tick();
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    // Drains n beats from both instances; with stall=1 every beat is held one cycle first.
    task automatic drain_beats(input int n, input logic stall);
        logic [7:0] ea, eb, held;
        for (int k = 0; k < n; k++) begin
            ea = 8'd64 + 8'(k);
            eb = 8'd252 + 8'(k);
            res_ready = ~stall;
            #1;
            chk("res_valid", {30'd0, res_valid_a, res_valid_b}, 32'd3);
            chk("raddr_a", {24'd0, dmem_raddr_a}, {24'd0, ea});
            chk("raddr_b", {24'd0, dmem_raddr_b}, {24'd0, eb});
            chk("rdata_a", {24'd0, res_data_a}, {24'd0, mem_f(ea)});
            chk("rdata_b", {24'd0, res_data_b}, {24'd0, mem_f(eb)});
            if (stall) begin
                held = res_data_a;
                tick();
                chk("stall_valid", {31'd0, res_valid_a}, 32'd1);
                chk("stall_data", {24'd0, res_data_a}, {24'd0, held});
                chk("stall_addr_b", {24'd0, dmem_raddr_b}, {24'd0, eb});
                res_ready = 1'b1;
            end
            tick();
        end
        res_ready = 1'b0;
    endtask

    initial begin
        logic seen;
        reset      = 1'b1;
        load_valid = 1'b0;
        load_data  = '0;
        load_last  = 1'b0;
        done       = 1'b0;
        res_ready  = 1'b0;
        repeat (3) tick();

        chk("rst_busy", {31'd0, busy_a}, 32'd0);
        chk("rst_start", {31'd0, start_a}, 32'd0);
        chk("rst_res_valid", {31'd0, res_valid_a}, 32'd0);
        chk("rst_imem_we", {31'd0, imem_we_a}, 32'd0);
        chk("rst_cycle_count", {16'd0, cycle_count_a}, 32'd0);
        chk("rst_timeout", {31'd0, timeout_a}, 32'd0);

        reset = 1'b0;
        tick();
        chk("ready_after_rst", {30'd0, load_ready_a, load_ready_b}, 32'd3);

        // done while idle must not start anything
        done = 1'b1;
        tick();
        done = 1'b0;
        chk("done_in_idle", {31'd0, busy_a}, 32'd0);

        // three-word program
        load_word(9'h101, 1'b0, 8'd0);
        load_word(9'h0A2, 1'b0, 8'd1);
        load_word(9'h1FF, 1'b1, 8'd2);
        #1;
        chk("start_pulse", {30'd0, start_a, start_b}, 32'd3);
        chk("busy_start", {31'd0, busy_a}, 32'd1);
        chk("ready_start", {31'd0, load_ready_a}, 32'd0);
        chk("we_start", {31'd0, imem_we_a}, 32'd0);
        tick();
        chk("start_one_cycle", {31'd0, start_a}, 32'd0);
        repeat (9) tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        chk("cycle_count_10", {16'd0, cycle_count_a}, 32'd10);
        drain_beats(8, 1'b1);
        chk("busy_after_drain", {30'd0, busy_a, busy_b}, 32'd0);
        chk("valid_after_drain", {30'd0, res_valid_a, res_valid_b}, 32'd0);
        chk("ready_after_drain", {31'd0, load_ready_a}, 32'd1);
        chk("count_held", {16'd0, cycle_count_a}, 32'd10);

        // wr_ptr back at 0 after the run, and wraps after 256 words
        for (int i = 0; i < 256; i++) begin
            load_word(9'(i), 1'b0, 8'(i));
        end
        load_word(9'h155, 1'b1, 8'd0);
        repeat (2) tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        chk("cycle_count_2", {16'd0, cycle_count_b}, 32'd2);
        drain_beats(8, 1'b0);
        chk("busy_after_drain2", {31'd0, busy_a}, 32'd0);

        // reset in the middle of a drain
        load_word(9'h0AA, 1'b1, 8'd0);
        tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        res_ready = 1'b1;
        drain_beats(3, 1'b0);
        res_ready = 1'b1;
        reset = 1'b1;
        #1;
        chk("rst_mid_valid", {30'd0, res_valid_a, res_valid_b}, 32'd0);
        chk("rst_mid_busy", {31'd0, busy_a}, 32'd0);
        tick();
        reset = 1'b0;
        res_ready = 1'b0;
        #1;
        chk("rst_mid_ready", {31'd0, load_ready_a}, 32'd1);
        seen = 1'b0;
        repeat (3) begin
            tick();
            if (res_valid_a || res_valid_b) seen = 1'b1;
        end
        chk("no_beats_after_rst", {31'd0, seen}, 32'd0);

        // wr_ptr cleared by reset; then a run whose core never finishes
        load_word(9'h0BB, 1'b1, 8'd0);
        seen = 1'b0;
        repeat (24) begin
            tick();
            if (res_valid_a || res_valid_b) seen = 1'b1;
        end
        chk("no_beats_on_hang", {31'd0, seen}, 32'd0);
`ifdef HOST_SEQ_TIMEOUT_EN
        chk("timeout_set", {30'd0, timeout_a, timeout_b}, 32'd3);
        chk("timeout_idle", {31'd0, busy_a}, 32'd0);
`else
        chk("hang_busy", {30'd0, busy_a, busy_b}, 32'd3);
        chk("hang_timeout", {31'd0, timeout_a}, 32'd0);
`endif

        reset = 1'b1;
        tick();
        reset = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
